// File: rtl/ready_valid_pkg.sv
// Shared constants and helpers for the ready/valid FIFO.
package ready_valid_pkg;

    localparam int RV_FIFO_MIN_DEPTH = 2;

    function automatic int rv_ptr_width(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/ready_valid_fifo_mem.sv
// DEPTH x DATA_WIDTH register array: synchronous write, combinational read, no reset.
module ready_valid_fifo_mem
    import ready_valid_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                             clk,
    input  logic                             we,
    input  logic [rv_ptr_width(DEPTH)-1:0]   waddr,
    input  logic [DATA_WIDTH-1:0]            wdata,
    input  logic [rv_ptr_width(DEPTH)-1:0]   raddr,
    output logic [DATA_WIDTH-1:0]            rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/ready_valid_fifo.sv
// Ready/valid FIFO with registered in_ready; optional empty-path bypass
// enabled by defining READY_VALID_FIFO_BYPASS_EN.
module ready_valid_fifo
    import ready_valid_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [DATA_WIDTH-1:0]     in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    output logic [DATA_WIDTH-1:0]     out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [$clog2(DEPTH):0]    level
);

    localparam int PTR_W = rv_ptr_width(DEPTH);

    typedef logic [PTR_W-1:0]      ptr_t;
    typedef logic [PTR_W:0]        count_t;
    typedef logic [DATA_WIDTH-1:0] data_t;

    localparam count_t DEPTH_C = count_t'(DEPTH);

    if (DEPTH < RV_FIFO_MIN_DEPTH || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("ready_valid_fifo: DEPTH must be a power of two and >= 2");
    end

    ptr_t   wr_ptr, rd_ptr;
    count_t count, count_next;
    data_t  mem_rdata;
    logic   empty, push_hs, bypass, wr_en, pop;

    assign empty   = (count == '0);
    assign push_hs = in_valid && in_ready;

`ifdef READY_VALID_FIFO_BYPASS_EN
    // An empty FIFO with a ready consumer hands the beat straight across.
    assign bypass    = empty && push_hs && out_ready;
    assign out_valid = empty ? push_hs : 1'b1;
    assign out_data  = empty ? in_data : mem_rdata;
`else
    assign bypass    = 1'b0;
    assign out_valid = !empty;
    assign out_data  = mem_rdata;
`endif

    assign wr_en = push_hs && !bypass;
    assign pop   = !empty && out_ready;

    always_comb begin
        count_next = count;
        if (wr_en && !pop)      count_next = count + count_t'(1);
        else if (!wr_en && pop) count_next = count - count_t'(1);
    end

    // in_ready comes from next-state count so it never sees out_ready combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            in_ready <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + ptr_t'(1);
            if (pop)   rd_ptr <= rd_ptr + ptr_t'(1);
            count    <= count_next;
            in_ready <= (count_next != DEPTH_C);
        end
    end

    assign level = count;

    ready_valid_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_ptr),
        .wdata (in_data),
        .raddr (rd_ptr),
        .rdata (mem_rdata)
    );

endmodule
